// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch display: core status codes, the
// active-low 7-segment pattern table and the double-dabble digit adjust.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } stat_e;

  // Segment order is {g,f,e,d,c,b,a}; a lit segment is driven low.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_TABLE [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    if (d > 4'd9) return SEG_BLANK;
    return SEG_TABLE[d];
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 converter: one load cycle plus eight shift cycles,
// then a one-cycle done pulse with two BCD digits. Input must be <= 99.
module bin2bcd_seq
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] bin_in,
  output logic       busy,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  // Handshake: start is accepted only while busy is low; done pulses for one
  // cycle after the last shift and tens/ones hold that result until the next start.
  typedef enum logic {B_IDLE, B_SHIFT} b_state_e;

  b_state_e   state_q, state_d;
  logic [7:0] bin_q, bin_d;
  logic [7:0] bcd_q, bcd_d;
  logic [2:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic [7:0] adj;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    adj     = {add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    case (state_q)
      B_IDLE: begin
        if (start) begin
          bin_d   = bin_in;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = B_SHIFT;
        end
      end
      B_SHIFT: begin
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = B_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = B_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= B_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // busy is the FSM state itself, so it doubles as the state observation point.
  assign busy = (state_q == B_SHIFT);
  assign done = done_q;
  assign tens = bcd_q[7:4];
  assign ones = bcd_q[3:0];

endmodule

// File: rtl/stopwatch_display.sv
// Drives a 4-digit multiplexed 7-segment display with MM.SS from a stopwatch
// core; the separator blinks while paused.
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int SCAN_DIV    = 1000,
  parameter int BLINK_SCANS = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mins,
  input  logic [5:0] secs,
  input  logic [1:0] stat,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]         digit_idx_q, digit_idx_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;
  logic [15:0]        disp_q, disp_d;
  logic [3:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;

  logic [7:0] mins_c, secs_c;
  logic       conv_start;
  logic       m_busy, m_done, s_busy, s_done;
  logic [3:0] m_tens, m_ones, s_tens, s_ones;
  logic       scan_wrap, round_wrap, dp_on;
  logic [3:0] digit;

  // Both converters start together whenever idle, so conversion runs back to back.
  assign conv_start = !m_busy && !s_busy;

  bin2bcd_seq u_mins_bcd (
    .clk(clk), .rst(rst), .start(conv_start), .bin_in(mins_c),
    .busy(m_busy), .done(m_done), .tens(m_tens), .ones(m_ones)
  );

  bin2bcd_seq u_secs_bcd (
    .clk(clk), .rst(rst), .start(conv_start), .bin_in(secs_c),
    .busy(s_busy), .done(s_done), .tens(s_tens), .ones(s_ones)
  );

  always_comb begin
    mins_c = (mins > 8'd99) ? 8'd99 : mins;
    secs_c = (secs > 6'd59) ? 8'd59 : {2'b00, secs};

    scan_wrap   = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
    digit_idx_d = scan_wrap ? digit_idx_q + 2'd1 : digit_idx_q;
    round_wrap  = scan_wrap && (digit_idx_q == 2'd3);

    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (round_wrap) begin
      if (blink_cnt_q == BLINK_W'(BLINK_SCANS - 1)) begin
        blink_cnt_d = '0;
        blink_d     = !blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end

    disp_d = (m_done && s_done) ? {m_tens, m_ones, s_tens, s_ones} : disp_q;

    // Outputs are decoded from next-state values so an/seg/dp line up with the index.
    digit = disp_d[{digit_idx_d, 2'b00} +: 4];
    if (digit_idx_d == 2'd3 && disp_d[15:12] == 4'd0) seg_d = SEG_BLANK;
    else                                             seg_d = seg_of(digit);
    an_d = ~(4'b0001 << digit_idx_d);

    case (stat)
      ST_RUN:   dp_on = 1'b1;
      ST_PAUSE: dp_on = blink_d;
      default:  dp_on = 1'b0;
    endcase
    dp_d = !((digit_idx_d == 2'd2) && dp_on);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q  <= '0;
      digit_idx_q <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      disp_q      <= '0;
      an_q        <= 4'b1111;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      disp_q      <= disp_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed bench for stopwatch_display with SCAN_DIV=4, BLINK_SCANS=2.
module tb_stopwatch_display;

  localparam int SCAN_DIV    = 4;
  localparam int BLINK_SCANS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mins = '0;
  logic [5:0] secs = '0;
  logic [1:0] stat = 2'b00;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned edge_cnt = 0;
  logic [11:0] exp_q[$];

  stopwatch_display #(.SCAN_DIV(SCAN_DIV), .BLINK_SCANS(BLINK_SCANS)) dut (
    .clk(clk), .rst(rst), .mins(mins), .secs(secs), .stat(stat),
    .seg(seg), .dp(dp), .an(an)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Rising edges since the last reset edge; index and blink phase follow from it.
  always @(posedge clk) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_time(input logic [7:0] m, input logic [5:0] s);
    @(negedge clk);
    mins = m;
    secs = s;
  endtask

  task automatic hold_reset(input string tag, input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check({tag, "/an"}, an, 4'hF);
      check({tag, "/seg"}, seg, 7'h7F);
      check({tag, "/dp"}, dp, 1'b1);
    end
    rst = 1'b0;
  endtask

  // Right after release the display register is 0000 until edge 10 loads the
  // first conversion; edges 1..9 cover digits 0, 1 and 2.
  task automatic check_cleared(input string tag);
    for (int i = 0; i < 9; i++) begin
      int         idx;
      logic [3:0] ea;
      logic       ed;
      @(negedge clk);
      idx = (edge_cnt / 4) % 4;
      ea  = ~(4'b0001 << idx);
      ed  = !(idx == 2 && stat == 2'b01);
      check({tag, "/an"}, an, ea);
      check({tag, "/seg"}, seg, 7'h40);
      check({tag, "/dp"}, dp, ed);
    end
  endtask

  // One full scan (16 cycles); d3..d0 are the expected patterns for digits 3..0.
  task automatic check_frame(input string tag, input logic [6:0] d3, input logic [6:0] d2,
                             input logic [6:0] d1, input logic [6:0] d0);
    logic [6:0] segs [4];
    segs = '{d0, d1, d2, d3};
    for (int i = 1; i <= 16; i++) begin
      int unsigned k;
      int          idx;
      logic        ph;
      logic        on;
      k   = edge_cnt + i;
      idx = (k / 4) % 4;
      ph  = ((k / 32) % 2) == 1;
      on  = (stat == 2'b01) || (stat == 2'b10 && ph);
      exp_q.push_back({~(4'b0001 << idx), segs[idx], !(idx == 2 && on)});
    end
    for (int i = 0; i < 16; i++) begin
      logic [11:0] e;
      @(negedge clk);
      e = exp_q.pop_front();
      check({tag, "/an"}, an, e[11:8]);
      check({tag, "/seg"}, seg, e[7:1]);
      check({tag, "/dp"}, dp, e[0]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    mins = 8'd12;
    secs = 6'd34;
    stat = 2'b01;
    hold_reset("reset", 5);
    check_cleared("post_reset");

    repeat (20) @(negedge clk);
    check_frame("run_12_34", 7'h79, 7'h24, 7'h30, 7'h19);

    set_time(8'd5, 6'd7);
    repeat (20) @(negedge clk);
    check_frame("run_05_07", 7'h7F, 7'h12, 7'h40, 7'h78);

    set_time(8'd150, 6'd63);
    repeat (20) @(negedge clk);
    check_frame("clamp_99_59", 7'h10, 7'h10, 7'h12, 7'h10);

    @(negedge clk);
    stat = 2'b10;
    for (int r = 0; r < 4; r++) check_frame("pause", 7'h10, 7'h10, 7'h12, 7'h10);
    stat = 2'b00;
    check_frame("idle", 7'h10, 7'h10, 7'h12, 7'h10);
    stat = 2'b11;
    check_frame("stat_11", 7'h10, 7'h10, 7'h12, 7'h10);

    stat = 2'b01;
    set_time(8'd42, 6'd63);
    repeat (3) @(negedge clk);
    hold_reset("mid_conv_reset", 3);
    check_cleared("after_abort");
    repeat (20) @(negedge clk);
    check_frame("run_42_59", 7'h19, 7'h24, 7'h12, 7'h10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_display.md
STOPWATCH_DISPLAY -- requirements
Module: stopwatch_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clk cycles per digit slot (must be ≥2).
REQ-002 SHALL have parameter BLINK_SCANS, default 64: full 4-digit scan rounds per blink half-period.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port mins, input, 8 bits: binary minutes from the stopwatch core.
REQ-006 SHALL have port secs, input, 6 bits: binary seconds from the stopwatch core.
REQ-007 SHALL have port stat, input, 2 bits: core status; 00 IDLE, 01 RUNNING, 10 PAUSED, 11 treated as IDLE.
REQ-008 SHALL have port seg, output, 7 bits: segments a..g (bit0 = a), active-low.
REQ-009 SHALL have port dp, output, 1 bit: decimal point / separator, active-low.
REQ-010 SHALL have port an, output, 4 bits: digit enables, active-low, one-hot.

Function
REQ-011 Conversion SHALL run continuously: snapshot mins/secs, then 8 shift-add-3 cycles (9 cycles total), then atomically update the 4-digit BCD display register.
REQ-012 Snapshot SHALL clamp mins > 99 to 99 and secs > 59 to 59.
REQ-013 Input changes during a conversion SHALL be ignored until the next snapshot; the display register SHALL reflect a stable input within 18 cycles.
REQ-014 Digit mapping SHALL be: index 0 = secs ones, 1 = secs tens, 2 = mins ones, 3 = mins tens; an[i] = 0 only when index i is active.
REQ-015 Scan counter SHALL count 0..SCAN_DIV-1; at wrap the digit index SHALL advance 0→1→2→3→0.
REQ-016 seg SHALL be the registered decode of the active digit (0-9 standard patterns), changing in the same cycle as an.
REQ-017 Digit 3 SHALL be blanked (seg = 7'h7F) when mins tens = 0; all other digits are never blanked.
REQ-018 dp SHALL be asserted (0) only while digit 2 is active and: RUNNING → steady on; PAUSED → on during blink phase 1 only; IDLE → off.
REQ-019 Blink phase SHALL toggle every BLINK_SCANS completed index-3→0 wraps; the blink counter free-runs regardless of stat.
REQ-020 stat SHALL be sampled every cycle (no snapshot); a stat change SHALL affect dp on the next cycle.

Reset
REQ-021 While rst = 1: an = 4'b1111, seg = 7'h7F, dp = 1, display register = 0000, scan counter = 0, digit index = 0, blink phase = 0, converter idle.
REQ-022 Reset mid-conversion SHALL abort it without updating the display register.
REQ-023 On the first cycle after rst falls, an SHALL be 4'b1110 showing "  00" (digit 3 blanked) until the first conversion completes.

Structure
REQ-024 A shared package stopwatch_pkg SHALL hold the stat encodings (ST_IDLE, ST_RUN, ST_PAUSE) and the 10-entry segment pattern table plus SEG_BLANK.
REQ-025 Sequential binary-to-BCD conversion SHALL be a sub-module bin2bcd_seq (start/busy/done handshake, 8-bit in, two BCD digits out), instantiated twice (mins, secs) and started together.
REQ-026 Target size: 120-400 lines RTL total.

Verification (SCAN_DIV = 4, BLINK_SCANS = 2 in bench)
REQ-027 Reset held 5 cycles → an = 1111, seg = 7F, dp = 1 throughout; after release an = 1110, seg = pattern "0".
REQ-028 mins = 12, secs = 34, stat = RUNNING, wait 20 cycles → digits 4,3,2,1 on an 1110/1101/1011/0111, dp = 0 only on 1011.
REQ-029 mins = 5, secs = 7 → digit 3 blank, digit 2 = 5, digits 1,0 = 0,7.
REQ-030 mins = 150, secs = 63 → displays 99:59.
REQ-031 stat = PAUSED for 64 cycles → dp on digit 2 alternates every 2 full scans (32 cycles); stat = IDLE → dp stays 1.
REQ-032 Assert rst during a conversion (cycle 4 after a mins change) → display returns to "  00" and all reset values hold.
